// File: rtl/gpio_defaults_sequencer.sv
// ---------------------------------------------------------------------------
// gpio_defaults_sequencer
//   Loads the GPIO pad configuration serial chain with each pad's default
//   control word. Words come from the tie-off default blocks through an
//   indexed combinational lookup (pad_idx -> pad_cfg). They are shifted MSB
//   first, starting with pad NUM_PADS-1 and ending with pad 0, and are then
//   committed with a serial_load strobe.
//
// Ports
//   clk, resetn    core clock, asynchronous active-low reset
//   start          request one sequence (sampled in IDLE only)
//   pad_cfg        default word for the pad selected by pad_idx
//   pad_idx        pad whose word is being fetched/shifted
//   serial_clock   chain shift clock (chain samples on the rising edge)
//   serial_data    chain data
//   serial_load    chain transfer strobe
//   serial_resetn  chain reset, active low
//   busy           sequence in progress (CHAIN_RST..LOAD)
//   done           one-cycle completion pulse
// ---------------------------------------------------------------------------
module gpio_defaults_sequencer #(
  parameter int NUM_PADS   = 38,
  parameter int CFG_W      = 13,
  parameter int CLK_DIV    = 2,
  parameter bit AUTO_START = 1'b1,
  // A single pad would give a zero-width index; keep at least one bit.
  localparam int IDX_W     = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [CFG_W-1:0] pad_cfg,
  output logic [IDX_W-1:0] pad_idx,
  output logic             serial_clock,
  output logic             serial_data,
  output logic             serial_load,
  output logic             serial_resetn,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = (CFG_W > 1) ? $clog2(CFG_W) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PADS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHAIN_RST, S_FETCH, S_SHIFT, S_LOAD, S_DONE
  } state_t;

  state_t             state_q;
  logic               auto_q;    // one automatic run pending after reset
  logic [DIV_W-1:0]   div_q;     // cycles spent in the current phase
  logic               phase_q;   // 0: serial_clock low half, 1: high half
  logic [BIT_W-1:0]   bit_q;     // bits still to shift after the current one
  logic [CFG_W-1:0]   sreg_q;
  logic [CFG_W-1:0]   sreg_shl;

  logic [IDX_W-1:0]   pad_idx_q;
  logic               sclk_q, sdat_q, sload_q, srst_q, busy_q, done_q;

  assign sreg_shl = sreg_q << 1;

  // Every output is set on the transition into the state that owns it, so
  // the registered value is already correct in that state's first cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      auto_q    <= AUTO_START;
      div_q     <= '0;
      phase_q   <= 1'b0;
      bit_q     <= '0;
      sreg_q    <= '0;
      pad_idx_q <= '0;
      sclk_q    <= 1'b0;
      sdat_q    <= 1'b0;
      sload_q   <= 1'b0;
      srst_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          srst_q <= 1'b1;
          if (start || auto_q) begin
            auto_q    <= 1'b0;
            pad_idx_q <= IDX_LAST;
            srst_q    <= 1'b0;
            busy_q    <= 1'b1;
            div_q     <= '0;
            state_q   <= S_CHAIN_RST;
          end
        end
        S_CHAIN_RST: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            srst_q  <= 1'b1;
            sclk_q  <= 1'b0;
            state_q <= S_FETCH;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_FETCH: begin
          // pad_idx_q already points at this pad, so pad_cfg is valid now.
          sreg_q  <= pad_cfg;
          bit_q   <= BIT_LAST;
          sdat_q  <= pad_cfg[CFG_W-1];
          sclk_q  <= 1'b0;
          phase_q <= 1'b0;
          div_q   <= '0;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_q != DIV_LAST) begin
            div_q <= div_q + DIV_W'(1);
          end else begin
            div_q <= '0;
            if (!phase_q) begin
              phase_q <= 1'b1;
              sclk_q  <= 1'b1;
            end else begin
              // End of high half: chain has sampled, advance to next bit.
              phase_q <= 1'b0;
              sclk_q  <= 1'b0;
              sreg_q  <= sreg_shl;
              if (bit_q != '0) begin
                bit_q  <= bit_q - BIT_W'(1);
                sdat_q <= sreg_shl[CFG_W-1];
              end else if (pad_idx_q != '0) begin
                pad_idx_q <= pad_idx_q - IDX_W'(1);
                state_q   <= S_FETCH;
              end else begin
                sload_q <= 1'b1;
                state_q <= S_LOAD;
              end
            end
          end
        end
        S_LOAD: begin
          if (div_q == DIV_LAST) begin
            div_q     <= '0;
            sload_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            pad_idx_q <= '0;
            state_q   <= S_DONE;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pad_idx       = pad_idx_q;
  assign serial_clock  = sclk_q;
  assign serial_data   = sdat_q;
  assign serial_load   = sload_q;
  assign serial_resetn = srst_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_gpio_defaults_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for gpio_defaults_sequencer. Four instances cover the configurations
// of interest:
//   0: AUTO_START=1, 2 pads x 4 bits, CLK_DIV=1 (own reset, aborted mid-run)
//   1: AUTO_START=0, 2 pads x 4 bits, CLK_DIV=1 (start-driven, vector table)
//   2: AUTO_START=1, 2 pads x 4 bits, CLK_DIV=3
//   3: AUTO_START=1, 1 pad  x 1 bit,  CLK_DIV=1
// Expected chain bits are queued when a sequence is triggered and popped by
// the monitor on every serial_clock rise.
// ---------------------------------------------------------------------------
module tb_gpio_defaults_sequencer;

  logic clk = 1'b0;
  logic rstn, rstn_a;
  logic [3:0] st, sclk, sdat, sld, srst, bsy, dn, idx;
  logic [2:0][3:0] cfg1, cfg0, pcfg;

  always #5 clk = ~clk;

  // Tie-off default lookup for the 2-pad instances.
  for (genvar i = 0; i < 3; i++) begin : g_lut
    assign pcfg[i] = idx[i] ? cfg1[i] : cfg0[i];
  end

  gpio_defaults_sequencer #(.NUM_PADS(2), .CFG_W(4), .CLK_DIV(1), .AUTO_START(1'b1)) u_a (
    .clk(clk), .resetn(rstn_a), .start(st[0]), .pad_cfg(pcfg[0]), .pad_idx(idx[0]),
    .serial_clock(sclk[0]), .serial_data(sdat[0]), .serial_load(sld[0]),
    .serial_resetn(srst[0]), .busy(bsy[0]), .done(dn[0]));

  gpio_defaults_sequencer #(.NUM_PADS(2), .CFG_W(4), .CLK_DIV(1), .AUTO_START(1'b0)) u_b (
    .clk(clk), .resetn(rstn), .start(st[1]), .pad_cfg(pcfg[1]), .pad_idx(idx[1]),
    .serial_clock(sclk[1]), .serial_data(sdat[1]), .serial_load(sld[1]),
    .serial_resetn(srst[1]), .busy(bsy[1]), .done(dn[1]));

  gpio_defaults_sequencer #(.NUM_PADS(2), .CFG_W(4), .CLK_DIV(3), .AUTO_START(1'b1)) u_c (
    .clk(clk), .resetn(rstn), .start(st[2]), .pad_cfg(pcfg[2]), .pad_idx(idx[2]),
    .serial_clock(sclk[2]), .serial_data(sdat[2]), .serial_load(sld[2]),
    .serial_resetn(srst[2]), .busy(bsy[2]), .done(dn[2]));

  gpio_defaults_sequencer #(.NUM_PADS(1), .CFG_W(1), .CLK_DIV(1), .AUTO_START(1'b1)) u_d (
    .clk(clk), .resetn(rstn), .start(st[3]), .pad_cfg(1'b1), .pad_idx(idx[3]),
    .serial_clock(sclk[3]), .serial_data(sdat[3]), .serial_load(sld[3]),
    .serial_resetn(srst[3]), .busy(bsy[3]), .done(dn[3]));

  // Per-instance expectations: busy length, serial_clock half-period, bits.
  localparam int LEN   [4] = '{20, 20, 56, 5};
  localparam int CDIV  [4] = '{1, 1, 3, 1};
  localparam int NBITS [4] = '{8, 8, 8, 1};

  int n_tests = 0;
  int n_fail  = 0;

  bit exp_q [4][$];
  int rise_cnt [4], done_cnt [4], load_cnt [4], busy_cnt [4], busy_rst [4];
  int hi_run [4], ld_run [4], seq_bits [4], idle_run [4];
  bit prev_sclk [4], prev_ld [4], prev_bsy [4], chk_gap [4];

  typedef struct packed {
    logic [3:0] p1;
    logic [3:0] p0;
    logic [7:0] exp_s;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string nm, input int d, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  task automatic push_stream(input int d, input logic [7:0] s, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q[d].push_back(s[i]);
  endtask

  task automatic pulse(input int d);
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int n);
    int g;
    g = 0;
    while (done_cnt[d] < n && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk("done_timeout", d, int'(done_cnt[d] >= n), 1);
  endtask

  // Monitor / scoreboard consumer.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (!(d == 0 ? rstn_a : rstn)) begin
        prev_sclk[d] = 1'b0; prev_ld[d] = 1'b0; prev_bsy[d] = 1'b0;
        rise_cnt[d] = 0; busy_cnt[d] = 0; busy_rst[d] = 0;
        hi_run[d] = 0; ld_run[d] = 0; seq_bits[d] = 0; idle_run[d] = 0;
      end else begin
        chk("clk_load_overlap", d, int'(sclk[d] & sld[d]), 0);
        if (bsy[d] && !prev_bsy[d]) begin
          if (chk_gap[d]) begin
            chk("retrigger_gap", d, idle_run[d], 1);
            chk_gap[d] = 1'b0;
          end
          busy_cnt[d] = 0; busy_rst[d] = 0; seq_bits[d] = 0;
        end
        if (sclk[d] && !prev_sclk[d]) begin
          rise_cnt[d]++;
          seq_bits[d]++;
          chk("bit_expected", d, int'(exp_q[d].size() > 0), 1);
          if (exp_q[d].size() > 0) chk("serial_data", d, int'(sdat[d]), int'(exp_q[d].pop_front()));
        end
        if (sclk[d]) hi_run[d]++;
        else if (prev_sclk[d]) begin
          chk("sclk_high_len", d, hi_run[d], CDIV[d]);
          hi_run[d] = 0;
        end
        if (sld[d]) begin
          if (!prev_ld[d]) load_cnt[d]++;
          ld_run[d]++;
        end else if (prev_ld[d]) begin
          chk("load_len", d, ld_run[d], CDIV[d]);
          ld_run[d] = 0;
        end
        if (bsy[d]) begin
          busy_cnt[d]++;
          if (!srst[d]) busy_rst[d]++;
        end
        if (!bsy[d] && !dn[d]) idle_run[d]++;
        if (dn[d]) begin
          done_cnt[d]++;
          chk("seq_len", d, busy_cnt[d], LEN[d]);
          chk("busy_at_done", d, int'(bsy[d]), 0);
          chk("idx_at_done", d, int'(idx[d]), 0);
          chk("chain_rst_len", d, busy_rst[d], CDIV[d]);
          chk("bits_per_seq", d, seq_bits[d], NBITS[d]);
          idle_run[d] = 0;
        end
        if (d == 3) chk("single_pad_idx", d, int'(idx[d]), 0);
        prev_sclk[d] = sclk[d];
        prev_ld[d]   = sld[d];
        prev_bsy[d]  = bsy[d];
      end
    end
  end

  initial begin
    int g;
    tbl[0] = '{4'hA, 4'h5, 8'hA5};
    tbl[1] = '{4'hF, 4'h0, 8'hF0};
    tbl[2] = '{4'h1, 4'h8, 8'h18};
    tbl[3] = '{4'h6, 4'hC, 8'h6C};
    st = '0;
    cfg1 = {3{4'hA}};
    cfg0 = {3{4'h5}};
    for (int d = 0; d < 4; d++) chk_gap[d] = 1'b0;
    rstn = 1'b1; rstn_a = 1'b1;
    #1 rstn = 1'b0; rstn_a = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("rst_sclk", d, int'(sclk[d]), 0);
      chk("rst_sdat", d, int'(sdat[d]), 0);
      chk("rst_load", d, int'(sld[d]), 0);
      chk("rst_chain_rstn", d, int'(srst[d]), 0);
      chk("rst_busy", d, int'(bsy[d]), 0);
      chk("rst_done", d, int'(dn[d]), 0);
      chk("rst_idx", d, int'(idx[d]), 0);
    end
    push_stream(0, 8'hA5, 8);
    push_stream(2, 8'hA5, 8);
    push_stream(3, 8'h01, 1);
    rstn = 1'b1; rstn_a = 1'b1;

    // Abort instance 0 after five bits have reached the chain.
    g = 0;
    while (rise_cnt[0] < 5 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("abort_point", 0, rise_cnt[0], 5);
    rstn_a = 1'b0;
    #1;
    chk("abort_sclk", 0, int'(sclk[0]), 0);
    chk("abort_sdat", 0, int'(sdat[0]), 0);
    chk("abort_load", 0, int'(sld[0]), 0);
    chk("abort_chain_rstn", 0, int'(srst[0]), 0);
    chk("abort_busy", 0, int'(bsy[0]), 0);
    chk("abort_done", 0, int'(dn[0]), 0);
    chk("abort_idx", 0, int'(idx[0]), 0);
    exp_q[0].delete();
    repeat (3) begin
      @(negedge clk);
      chk("load_in_reset", 0, int'(sld[0]), 0);
    end
    push_stream(0, 8'hA5, 8);
    rstn_a = 1'b1;

    // Instance 1 has no auto start: it must stay quiet.
    repeat (50) begin
      @(negedge clk);
      chk("idle_busy", 1, int'(bsy[1]), 0);
      chk("idle_sclk", 1, int'(sclk[1]), 0);
      chk("idle_load", 1, int'(sld[1]), 0);
    end
    wait_done(0, 1);
    wait_done(2, 1);
    wait_done(3, 1);

    // Vector table on instance 1.
    for (int k = 0; k < 4; k++) begin
      cfg1[1] = tbl[k].p1;
      cfg0[1] = tbl[k].p0;
      push_stream(1, tbl[k].exp_s, 8);
      pulse(1);
      wait_done(1, k + 1);
      repeat (2) @(negedge clk);
    end

    // Start pulsed repeatedly while busy: exactly one sequence.
    cfg1[1] = 4'hA;
    cfg0[1] = 4'h5;
    push_stream(1, 8'hA5, 8);
    pulse(1);
    repeat (5) begin
      @(negedge clk);
      st[1] = 1'b1;
      @(negedge clk);
      st[1] = 1'b0;
      @(negedge clk);
    end
    wait_done(1, 5);
    repeat (30) @(negedge clk);
    chk("single_done", 1, done_cnt[1], 5);

    // Start held high: a second run follows after one IDLE cycle.
    push_stream(1, 8'hA5, 8);
    push_stream(1, 8'hA5, 8);
    st[1] = 1'b1;
    wait_done(1, 6);
    chk_gap[1] = 1'b1;
    repeat (3) @(negedge clk);
    st[1] = 1'b0;
    wait_done(1, 7);
    repeat (30) @(negedge clk);

    chk("final_done_a", 0, done_cnt[0], 1);
    chk("final_done_b", 1, done_cnt[1], 7);
    chk("final_done_c", 2, done_cnt[2], 1);
    chk("final_done_d", 3, done_cnt[3], 1);
    chk("final_load_a", 0, load_cnt[0], 1);
    chk("final_load_b", 1, load_cnt[1], 7);
    chk("final_load_c", 2, load_cnt[2], 1);
    chk("final_load_d", 3, load_cnt[3], 1);
    for (int d = 0; d < 4; d++) chk("queue_drained", d, exp_q[d].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
